// File: rtl/sram_mem_ctrl_pkg.sv
// Shared types and defaults for the SRAM memory-stage controller.
package sram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int unsigned DEF_ADDR_W      = 32;
  localparam int unsigned DEF_WORD_W      = 32;
  localparam int unsigned DEF_SRAM_DW     = 16;
  localparam int unsigned DEF_SRAM_AW     = 18;
  localparam int unsigned DEF_WAIT_STATES = 1;
  localparam int unsigned DEF_BASE_ADDR   = 1024;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_beat_seq.sv
// Beat / wait-state sequencer: steps through BEATS beats of WAIT_STATES+1 cycles.
module sram_beat_sequencer
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned BEATS       = 2,
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned BW          = cnt_w(BEATS),
  parameter int unsigned WW          = cnt_w(WAIT_STATES + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [BW-1:0] beat,
  output logic [WW-1:0] wait_cnt,
  output logic          last_wait,
  output logic          last_beat
);

  assign last_wait = (wait_cnt == WW'(WAIT_STATES));
  assign last_beat = (beat == BW'(BEATS - 1));

  // Counters run only while an access is in progress and sit at zero otherwise.
  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      beat     <= '0;
      wait_cnt <= '0;
    end else if (last_wait) begin
      wait_cnt <= '0;
      beat     <= last_beat ? '0 : beat + 1'b1;
    end else begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sram_mem_ctrl.sv
// Memory-stage SRAM controller: splits one word access into narrow SRAM beats
// and freezes the pipeline via ready until the access completes.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned WORD_W      = DEF_WORD_W,
  parameter int unsigned SRAM_DW     = DEF_SRAM_DW,
  parameter int unsigned SRAM_AW     = DEF_SRAM_AW,
  parameter int unsigned WAIT_STATES = DEF_WAIT_STATES,
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               write_en,
  input  logic               read_en,
  input  logic [ADDR_W-1:0]  address,
  input  logic [WORD_W-1:0]  writeData,
  output logic [WORD_W-1:0]  readData,
  output logic               ready,
  output logic               err,
  inout  logic [SRAM_DW-1:0] SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  localparam int unsigned BEATS   = WORD_W / SRAM_DW;
  localparam int unsigned OFF     = $clog2(WORD_W / 8);
  localparam int unsigned BW      = cnt_w(BEATS);
  localparam int unsigned WW      = cnt_w(WAIT_STATES + 1);
  localparam int unsigned XW      = ADDR_W + BW + 1;
  localparam bit          WS_ZERO = (WAIT_STATES == 0);

  state_t              state;
  logic                is_write;
  logic [WORD_W-1:0]   wdata_q;
  logic [WORD_W-1:0]   rbuf;
  logic [WORD_W-1:0]   rbuf_nx;
  logic [WORD_W-1:0]   read_data_q;
  logic                err_q;
  logic [SRAM_AW-1:0]  sram_addr_q;
  logic [SRAM_DW-1:0]  wslice;

  logic                req;
  logic                access;
  logic                drive;
  logic [ADDR_W-1:0]   rel;
  logic [XW-1:0]       first_loc;
  logic [XW-1:0]       last_loc;
  logic                in_range;

  logic [BW-1:0]       beat;
  logic [WW-1:0]       wait_cnt;
  logic                last_wait;
  logic                last_beat;

  assign req    = write_en | read_en;
  assign access = (state == ST_ACCESS);
  assign drive  = access & is_write;

  assign rel       = address - ADDR_W'(BASE_ADDR);
  assign first_loc = XW'(rel >> OFF) * XW'(BEATS);
  assign last_loc  = first_loc + XW'(BEATS - 1);
  assign in_range  = (address >= ADDR_W'(BASE_ADDR)) && ((last_loc >> SRAM_AW) == '0);

  sram_beat_sequencer #(
    .BEATS       (BEATS),
    .WAIT_STATES (WAIT_STATES),
    .BW          (BW),
    .WW          (WW)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .run       (access),
    .beat      (beat),
    .wait_cnt  (wait_cnt),
    .last_wait (last_wait),
    .last_beat (last_beat)
  );

  // Read buffer with the current beat's slice merged in, so the final beat is
  // included in readData on the same edge that enters DONE.
  always_comb begin
    rbuf_nx = rbuf;
    rbuf_nx[beat*SRAM_DW +: SRAM_DW] = SRAM_DQ;
  end

  assign wslice = wdata_q[beat*SRAM_DW +: SRAM_DW];

  // Access FSM with registered address, read data and error flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      is_write    <= 1'b0;
      wdata_q     <= '0;
      rbuf        <= '0;
      read_data_q <= '0;
      err_q       <= 1'b0;
      sram_addr_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            is_write <= write_en;
            wdata_q  <= writeData;
            if (in_range) begin
              state       <= ST_ACCESS;
              sram_addr_q <= first_loc[SRAM_AW-1:0];
            end else begin
              state <= ST_DONE;
              err_q <= 1'b1;
              if (!write_en) read_data_q <= '0;
            end
          end
        end
        ST_ACCESS: begin
          if (last_wait) begin
            if (!is_write) rbuf <= rbuf_nx;
            if (last_beat) begin
              state <= ST_DONE;
              if (!is_write) read_data_q <= rbuf_nx;
            end else begin
              sram_addr_q <= sram_addr_q + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          err_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // WE_N is released on the last wait cycle so address/data are stable at its
  // rising edge; with no wait states the single cycle must carry the pulse.
  assign SRAM_WE_N = ~(drive & (~last_wait | WS_ZERO));
  assign SRAM_OE_N = ~(access & ~is_write);
  assign SRAM_DQ   = drive ? wslice : {SRAM_DW{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  assign ready    = ((state == ST_IDLE) & ~req) | (state == ST_DONE);
  assign readData = read_data_q;
  assign err      = err_q;

endmodule
